// File: rtl/fxp_block_accumulator.sv
// Block multiply-accumulate: sums up to BLOCK_LEN exact Q8.8 x Q8.8 products and emits one
// saturated Q16.16 result per block over a valid/ready handshake.
module fxp_block_accumulator #(
    parameter int unsigned FXP_WIDTH = 16,
    parameter int unsigned FXP_FRAC  = 8,
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned BLOCK_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FXP_WIDTH-1:0] in_sample,
    input  logic [FXP_WIDTH-1:0] in_coef,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sample,
    output logic                 out_sat,
    output logic [7:0]           out_count
);

    localparam int unsigned ProdW = 2 * FXP_WIDTH;
    // Headroom so a full block of worst-case products can never wrap.
    localparam int unsigned AccW  = ACC_WIDTH + $clog2(BLOCK_LEN) + 1;

    localparam logic [7:0] LastIdx = 8'(BLOCK_LEN - 1);

    localparam logic signed [AccW-1:0] SatMax =
        {{(AccW - ACC_WIDTH + 1){1'b0}}, {(ACC_WIDTH - 1){1'b1}}};
    localparam logic signed [AccW-1:0] SatMin =
        {{(AccW - ACC_WIDTH + 1){1'b1}}, {(ACC_WIDTH - 1){1'b0}}};

    localparam logic [ACC_WIDTH-1:0] OutMax = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] OutMin = {1'b1, {(ACC_WIDTH - 1){1'b0}}};

    if (ACC_WIDTH != 2 * FXP_WIDTH || FXP_FRAC >= FXP_WIDTH || BLOCK_LEN == 0
        || BLOCK_LEN > 256) begin : g_param_check
        $error("fxp_block_accumulator: illegal parameter combination");
    end

    typedef enum logic {StAccum, StEmit} state_e;

    state_e                 state_q, state_d;
    logic signed [AccW-1:0] acc_q, acc_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]   sample_q, sample_d;
    logic                   sat_q, sat_d;
    logic [7:0]             count_q, count_d;

    logic signed [ProdW-1:0] prod;
    logic signed [AccW-1:0]  prod_ext;
    logic signed [AccW-1:0]  acc_sum;
    logic [ACC_WIDTH-1:0]    sum_sat;
    logic                    sum_clip;
    logic                    close_block;

    assign prod     = $signed(in_sample) * $signed(in_coef);
    assign prod_ext = {{(AccW - ProdW){prod[ProdW-1]}}, prod};
    assign acc_sum  = acc_q + prod_ext;

    always_comb begin
        sum_sat  = acc_sum[ACC_WIDTH-1:0];
        sum_clip = 1'b0;
        if (acc_sum > SatMax) begin
            sum_sat  = OutMax;
            sum_clip = 1'b1;
        end else if (acc_sum < SatMin) begin
            sum_sat  = OutMin;
            sum_clip = 1'b1;
        end
    end

    // in_last on the final counted beat still closes the block only once.
    assign close_block = in_last || (cnt_q == LastIdx);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        sat_d    = sat_q;
        count_d  = count_q;
        case (state_q)
            StAccum: begin
                if (in_valid) begin
                    if (close_block) begin
                        sample_d = sum_sat;
                        sat_d    = sum_clip;
                        count_d  = cnt_q + 8'd1;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = StEmit;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StEmit: begin
                if (out_ready) begin
                    state_d = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StAccum;
            acc_q    <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
            sat_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            sat_q    <= sat_d;
            count_q  <= count_d;
        end
    end

    // Handshake flags decode the registered state only; out_ready never reaches in_ready.
    assign in_ready   = (state_q == StAccum);
    assign out_valid  = (state_q == StEmit);
    assign out_sample = sample_q;
    assign out_sat    = sat_q;
    assign out_count  = count_q;

endmodule

// File: tb/tb_fxp_block_accumulator.sv
// Bench for fxp_block_accumulator: directed cases then randomized traffic against a
// block-level arithmetic model of the expected output stream.
module tb_fxp_block_accumulator;

    localparam int unsigned BlockLen = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_sample = '0;
    logic [15:0] in_coef = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_sample;
    logic        out_sat;
    logic [7:0]  out_count;

    fxp_block_accumulator #(
        .FXP_WIDTH(16),
        .FXP_FRAC (8),
        .ACC_WIDTH(32),
        .BLOCK_LEN(BlockLen)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .in_coef   (in_coef),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sample(out_sample),
        .out_sat   (out_sat),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] sample;
        logic        sat;
        logic [7:0]  count;
    } blk_t;

    int     checks = 0;
    int     errors = 0;
    blk_t   exp_q[$];
    longint m_sum = 0;
    int     m_cnt = 0;
    bit     pending = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic blk_t close_model(input longint sum, input int cnt);
        blk_t b;
        if (sum > 64'sd2147483647) begin
            b.sample = 32'h7FFF_FFFF;
            b.sat    = 1'b1;
        end else if (sum < -64'sd2147483648) begin
            b.sample = 32'h8000_0000;
            b.sat    = 1'b1;
        end else begin
            b.sample = sum[31:0];
            b.sat    = 1'b0;
        end
        b.count = 8'(cnt);
        return b;
    endfunction

    // One clock: compare at the falling edge, advance the model, return 1 time unit after
    // the rising edge.
    task automatic step();
        bit in_fire;
        bit out_fire;
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            m_sum   = 0;
            m_cnt   = 0;
            pending = 1'b0;
        end else begin
            chk("in_ready", 32'(in_ready), 32'(!pending));
            chk("out_valid", 32'(out_valid), 32'(pending));
            if (pending && exp_q.size() > 0) begin
                chk("out_sample", out_sample, exp_q[0].sample);
                chk("out_sat", 32'(out_sat), 32'(exp_q[0].sat));
                chk("out_count", 32'(out_count), 32'(exp_q[0].count));
            end
            in_fire  = in_valid && !pending;
            out_fire = pending && out_ready;
            if (out_fire) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                pending = 1'b0;
            end
            if (in_fire) begin
                m_sum += longint'($signed(in_sample)) * longint'($signed(in_coef));
                m_cnt++;
                if (in_last || m_cnt == BlockLen) begin
                    exp_q.push_back(close_model(m_sum, m_cnt));
                    m_sum   = 0;
                    m_cnt   = 0;
                    pending = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [15:0] s, input logic [15:0] c, input logic last);
        bit taken;
        in_valid  = 1'b1;
        in_sample = s;
        in_coef   = c;
        in_last   = last;
        for (int i = 0; i < 50; i++) begin
            taken = !pending;
            step();
            if (taken) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $error("FAIL send_timeout: observed no accept expected accept within 50 cycles");
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_sample", out_sample, 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] s, input logic sat,
                              input logic [7:0] cnt);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sample"}, out_sample, s);
        chk({tag, "_sat"}, 32'(out_sat), 32'(sat));
        chk({tag, "_count"}, 32'(out_count), 32'(cnt));
    endtask

    initial begin
        do_reset();

        // 1.0 * 1.0 four times
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(16'h0100, 16'h0100, 1'b0);
        expect_out("unity", 32'h0004_0000, 1'b0, 8'd4);
        step();

        // 0.5 * -1.0 twice, closed early
        send_beat(16'h0080, 16'hFF00, 1'b0);
        send_beat(16'h0080, 16'hFF00, 1'b1);
        expect_out("early", 32'hFFFF_0000, 1'b0, 8'd2);
        step();

        for (int i = 0; i < 4; i++) send_beat(16'h7FFF, 16'h7FFF, 1'b0);
        expect_out("sat_pos", 32'h7FFF_FFFF, 1'b1, 8'd4);
        step();
        for (int i = 0; i < 4; i++) send_beat(16'h8000, 16'h7FFF, 1'b0);
        expect_out("sat_neg", 32'h8000_0000, 1'b1, 8'd4);
        step();

        // in_last on the final beat closes once; the following single beat is its own block
        for (int i = 0; i < 4; i++) send_beat(16'h0200, 16'h0100, i == 3);
        expect_out("last_on_full", 32'h0008_0000, 1'b0, 8'd4);
        step();
        send_beat(16'h0100, 16'h0300, 1'b1);
        expect_out("single", 32'h0003_0000, 1'b0, 8'd1);
        step();

        // Backpressure: result held, input offered but refused
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(16'h0100, 16'h0100, 1'b0);
        in_valid  = 1'b1;
        in_sample = 16'h0100;
        in_coef   = 16'h0500;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_sample", out_sample, 32'h0004_0000);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);

        // Abort mid-block with reset; no residue carried forward
        send_beat(16'h1000, 16'h1000, 1'b0);
        send_beat(16'h1000, 16'h1000, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) send_beat(16'h0100, 16'h0100, 1'b0);
        expect_out("post_reset", 32'h0004_0000, 1'b0, 8'd4);
        step();

        // Randomized traffic with gaps on both sides
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) begin
                in_sample = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
                in_coef   = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
            end else begin
                in_sample = 16'($urandom);
                in_coef   = 16'($urandom);
            end
            in_last   = ($urandom_range(0, 4) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            step();
        end

        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
